// File: rtl/joy_db15_pkg.sv
// rtl/joy_db15_pkg.sv - shared types and constants for the DB15 joystick responder
package joy_db15_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } joy_state_e;

  localparam int WORD_BITS_DEF = 16;
  localparam int FRAME_BITS    = 2 * WORD_BITS_DEF;

  // Button bit positions inside each player's word
  localparam int BTN_R      = 0;
  localparam int BTN_L      = 1;
  localparam int BTN_D      = 2;
  localparam int BTN_U      = 3;
  localparam int BTN_FIRE   = 4;
  localparam int BTN_START1 = 5;
  localparam int BTN_START2 = 6;
  localparam int BTN_COIN   = 7;

endpackage

// File: rtl/joy_db15_pin_cond.sv
// rtl/joy_db15_pin_cond.sv - pin synchronizer, consecutive-sample filter and edge pulses
module db15_pin_cond #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER      = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = (FILTER > 1) ? $clog2(FILTER) : 1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   prev_q, prev_d;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Shift the pin through the synchronizer and accept a new level only after
  // FILTER consecutive samples that disagree with the current filtered level
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], pin};
    cnt_d   = '0;
    level_d = level_q;
    prev_d  = level_q;
    if (sync_out != level_q) begin
      if (cnt_q == CW'(FILTER - 1)) begin
        level_d = sync_out;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Pins idle high, so everything presets to 1 and no edge appears out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '1;
      cnt_q   <= '0;
      level_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      prev_q  <= prev_d;
    end
  end

  assign level = level_q;
  assign rise  = level_q & ~prev_q;
  assign fall  = ~level_q & prev_q;

endmodule

// File: rtl/joy_db15_tx.sv
// rtl/joy_db15_tx.sv - device-side DB15 joystick shift-chain responder
module joy_db15_tx
  import joy_db15_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER      = 2,
  parameter int WORD_BITS   = WORD_BITS_DEF,
  parameter int TIMEOUT     = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_BITS-1:0] joystick1,
  input  logic [WORD_BITS-1:0] joystick2,
  input  logic                 joy_load,
  input  logic                 joy_clk,
  output logic                 joy_data,
  output logic                 busy,
  output logic [5:0]           bit_index,
  output logic                 frame_done,
  output logic                 timeout_err
);

  localparam int FW = 2 * WORD_BITS;
  localparam int TW = $clog2(TIMEOUT + 1);

  logic load_level, load_rise, load_fall;
  logic clk_level, clk_rise, clk_fall;
  logic unused_pins;

  db15_pin_cond #(.SYNC_STAGES(SYNC_STAGES), .FILTER(FILTER)) u_load_cond (
    .clk   (clk),
    .rst   (reset),
    .pin   (joy_load),
    .level (load_level),
    .rise  (load_rise),
    .fall  (load_fall)
  );

  db15_pin_cond #(.SYNC_STAGES(SYNC_STAGES), .FILTER(FILTER)) u_clk_cond (
    .clk   (clk),
    .rst   (reset),
    .pin   (joy_clk),
    .level (clk_level),
    .rise  (clk_rise),
    .fall  (clk_fall)
  );

  // Load is level-driven so a held-low strobe keeps the chain transparent
  assign unused_pins = &{load_fall, clk_level, clk_fall};

  joy_state_e    state_q, state_d;
  logic [FW-1:0] shreg_q, shreg_d;
  logic [5:0]    bit_index_q, bit_index_d;
  logic          joy_data_q, joy_data_d;
  logic          frame_done_q, frame_done_d;
  logic          timeout_err_q, timeout_err_d;
  logic [TW-1:0] tmo_q, tmo_d;

  // Next-state and output logic; a low load always wins over a clock rise
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    bit_index_d   = bit_index_q;
    joy_data_d    = joy_data_q;
    frame_done_d  = 1'b0;
    timeout_err_d = 1'b0;
    tmo_d         = '0;

    case (state_q)
      IDLE: begin
        joy_data_d  = 1'b1;
        bit_index_d = '0;
        shreg_d     = '1;
        if (!load_level) begin
          state_d    = LOAD;
          shreg_d    = {~joystick2, ~joystick1};
          joy_data_d = ~joystick1[0];
        end
      end

      LOAD: begin
        bit_index_d = '0;
        if (load_rise) begin
          state_d = SHIFT;
        end else begin
          shreg_d    = {~joystick2, ~joystick1};
          joy_data_d = ~joystick1[0];
        end
      end

      SHIFT: begin
        if (!load_level) begin
          state_d     = LOAD;
          shreg_d     = {~joystick2, ~joystick1};
          joy_data_d  = ~joystick1[0];
          bit_index_d = '0;
        end else if (clk_rise) begin
          if (bit_index_q == 6'(FW - 1)) begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
            joy_data_d   = 1'b1;
            bit_index_d  = '0;
            shreg_d      = '1;
          end else begin
            shreg_d     = {1'b1, shreg_q[FW-1:1]};
            joy_data_d  = shreg_q[1];
            bit_index_d = bit_index_q + 6'd1;
          end
        end else if (tmo_q >= TW'(TIMEOUT - 1)) begin
          state_d       = IDLE;
          timeout_err_d = 1'b1;
          joy_data_d    = 1'b1;
          bit_index_d   = '0;
          shreg_d       = '1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        joy_data_d  = 1'b1;
        bit_index_d = '0;
        shreg_d     = '1;
      end
    endcase
  end

  // State and output registers; reset drops everything to the released pin state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      shreg_q       <= '1;
      bit_index_q   <= '0;
      joy_data_q    <= 1'b1;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      tmo_q         <= '0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bit_index_q   <= bit_index_d;
      joy_data_q    <= joy_data_d;
      frame_done_q  <= frame_done_d;
      timeout_err_q <= timeout_err_d;
      tmo_q         <= tmo_d;
    end
  end

  assign joy_data    = joy_data_q;
  assign busy        = (state_q != IDLE);
  assign bit_index   = bit_index_q;
  assign frame_done  = frame_done_q;
  assign timeout_err = timeout_err_q;

endmodule
